// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared types and helpers for the parametrised SRAM FIFO.
//   state_t  : control FSM states (IDLE = empty, ACTIVE = partially filled,
//              FULL = holds DEPTH words)
//   ptr_wrap : advance a pointer by one, wrapping to 0 after depth-1. Works
//              for any depth, so non-power-of-two FIFOs wrap correctly.
// ---------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } state_t;

    function automatic int unsigned ptr_wrap(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr_gen.sv
// ---------------------------------------------------------------------------
// fifo_ptr_gen
// Single wrapping address pointer. One instance drives the write address and
// a second drives the read address of the FIFO memory.
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset, pointer -> 0
//   clear : synchronous flush, pointer -> 0
//   inc   : advance the pointer by one (wraps after DEPTH-1)
//   ptr   : current pointer value
// ---------------------------------------------------------------------------
module fifo_ptr_gen
    import fifo_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    logic [ADDR_W-1:0] r_ptr;

    // Pointer register; reset and flush both return it to address 0.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= ADDR_W'(ptr_wrap(32'(r_ptr), DEPTH));
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/param_ag_sram_fifo.sv
// ---------------------------------------------------------------------------
// param_ag_sram_fifo
// Address generator plus inferred on-chip SRAM used as a FIFO between the
// I2C byte interface and the DES block-assembly logic.
// Optional build macro: FIFO_PARITY_EN (stores an even parity bit per word
// and pulses parity_err alongside rd_valid when a read word fails the check).
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   clear           : synchronous flush of pointers/count/flags, memory kept
//   wr_en, wr_data  : write request and word
//   rd_en           : read request
//   rd_data         : read word, qualified by the rd_valid pulse
//   full, empty     : status decoded from the control FSM
//   count           : number of stored words (0..DEPTH)
//   overflow        : sticky, write attempted while full
//   underflow       : sticky, read attempted while empty
//   parity_err      : parity mismatch on the delivered word (0 when disabled)
// ---------------------------------------------------------------------------
module param_ag_sram_fifo
    import fifo_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              parity_err
);

`ifdef FIFO_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0]  r_mem [DEPTH];
    state_t            r_state;
    state_t            w_stateNext;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_countNext;
    logic [ADDR_W-1:0] w_wrPtr;
    logic [ADDR_W-1:0] w_rdPtr;
    logic [MEM_W-1:0]  w_rdWord;
    logic [DATA_W-1:0] r_rdData;
    logic              r_rdValid;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_flush;
    logic              w_wrAcc;
    logic              w_rdAcc;

    // Reset and clear both flush; any request in a flush cycle is ignored.
    assign w_flush  = rst | clear;
    assign full     = (r_state == FULL);
    assign empty    = (r_state == IDLE);
    assign w_wrAcc  = wr_en & ~full  & ~w_flush;
    assign w_rdAcc  = rd_en & ~empty & ~w_flush;
    assign w_rdWord = r_mem[w_rdPtr];

    fifo_ptr_gen #(.DEPTH(DEPTH)) u_wrPtr (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (w_wrAcc),
        .ptr   (w_wrPtr)
    );

    fifo_ptr_gen #(.DEPTH(DEPTH)) u_rdPtr (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (w_rdAcc),
        .ptr   (w_rdPtr)
    );

    // Next count and next FSM state. Because a full FIFO never accepts a
    // write and an empty one never accepts a read, there is no pass-through
    // or bypass path and the count can never leave 0..DEPTH.
    always_comb begin
        w_countNext = r_count;
        w_stateNext = r_state;
        case ({w_wrAcc, w_rdAcc})
            2'b10:   w_countNext = r_count + (ADDR_W+1)'(1);
            2'b01:   w_countNext = r_count - (ADDR_W+1)'(1);
            default: w_countNext = r_count;
        endcase
        if (w_flush) begin
            w_stateNext = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_wrAcc) w_stateNext = ACTIVE;
                ACTIVE: begin
                    if (w_countNext == (ADDR_W+1)'(DEPTH)) begin
                        w_stateNext = FULL;
                    end else if (w_countNext == '0) begin
                        w_stateNext = IDLE;
                    end
                end
                FULL:    if (w_rdAcc) w_stateNext = ACTIVE;
                default: w_stateNext = IDLE;
            endcase
        end
    end

    // FSM state and occupancy count.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_stateNext;
            r_count <= w_countNext;
        end
    end

    // Storage array; never reset so it maps onto plain SRAM.
    always_ff @(posedge clk) begin
        if (w_wrAcc) begin
`ifdef FIFO_PARITY_EN
            r_mem[w_wrPtr] <= {^wr_data, wr_data};
`else
            r_mem[w_wrPtr] <= wr_data;
`endif
        end
    end

    // Read port: rd_data only clears on reset; clear leaves the last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdData <= '0;
        end else if (w_rdAcc) begin
            r_rdData <= w_rdWord[DATA_W-1:0];
        end
    end

    // Read strobe and sticky error flags.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_rdValid   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rdValid <= w_rdAcc;
            if (wr_en && full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_PARITY_EN
    logic r_parityErr;

    // The stored word carries even parity, so a good word XORs to 0.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_parityErr <= 1'b0;
        end else begin
            r_parityErr <= w_rdAcc & (^w_rdWord);
        end
    end

    assign parity_err = r_parityErr;
`else
    assign parity_err = 1'b0;
`endif

    assign rd_data   = r_rdData;
    assign rd_valid  = r_rdValid;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_param_ag_sram_fifo.sv
// ---------------------------------------------------------------------------
// tb_param_ag_sram_fifo
// Self-checking bench for param_ag_sram_fifo. A DEPTH=16 instance is checked
// against a queue-based reference model; a DEPTH=5 instance exercises pointer
// wrap on a non-power-of-two depth.
// ---------------------------------------------------------------------------
module tb_param_ag_sram_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic       clk = 1'b0;
    logic       rst, clear, wrEn, rdEn;
    logic [7:0] wrData;
    logic [7:0] rdData;
    logic       rdValid, full, empty, overflow, underflow, parityErr;
    logic [4:0] count;

    logic       rst5, clear5, wrEn5, rdEn5;
    logic [7:0] wrData5;
    logic [7:0] rdData5;
    logic       rdValid5, full5, empty5, overflow5, underflow5, parityErr5;
    logic [3:0] count5;

    int errors = 0;
    int checks = 0;

    // Reference model state: queue of stored words plus expected outputs.
    logic [7:0] q[$];
    logic [7:0] mRdData = 8'h00;
    bit         mValid  = 1'b0;
    bit         mOvf    = 1'b0;
    bit         mUdf    = 1'b0;

    always #5 clk = ~clk;

    param_ag_sram_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .wr_en      (wrEn),
        .wr_data    (wrData),
        .rd_en      (rdEn),
        .rd_data    (rdData),
        .rd_valid   (rdValid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow),
        .parity_err (parityErr)
    );

    param_ag_sram_fifo #(.DATA_W(8), .DEPTH(5)) u_dut5 (
        .clk        (clk),
        .rst        (rst5),
        .clear      (clear5),
        .wr_en      (wrEn5),
        .wr_data    (wrData5),
        .rd_en      (rdEn5),
        .rd_data    (rdData5),
        .rd_valid   (rdValid5),
        .full       (full5),
        .empty      (empty5),
        .count      (count5),
        .overflow   (overflow5),
        .underflow  (underflow5),
        .parity_err (parityErr5)
    );

    // Drive one cycle on the DEPTH=16 instance and advance the model.
    task automatic step(input bit w, input logic [7:0] d, input bit r,
                        input bit c, input bit rs);
        bit isFull, isEmpty;
        wrEn = w; wrData = d; rdEn = r; clear = c; rst = rs;
        isFull  = (q.size() == DEPTH);
        isEmpty = (q.size() == 0);
        mValid  = 1'b0;
        if (rs) begin
            q.delete(); mRdData = 8'h00; mOvf = 0; mUdf = 0;
        end else if (c) begin
            q.delete(); mOvf = 0; mUdf = 0;
        end else begin
            if (w && isFull) mOvf = 1;
            if (r && isEmpty) mUdf = 1;
            if (r && !isEmpty) begin
                mRdData = q.pop_front();
                mValid  = 1'b1;
            end
            if (w && !isFull) q.push_back(d);
        end
        @(posedge clk); #1;
    endtask

    // Drive one cycle on the DEPTH=5 instance (checked against constants).
    task automatic step5(input bit w, input logic [7:0] d, input bit r, input bit rs);
        wrEn5 = w; wrData5 = d; rdEn5 = r; rst5 = rs; clear5 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        step(1, 8'h55, 1, 0, 1);
        checks += 7;
        if (count !== 5'd0)   begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        if (empty !== 1'b1)   begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
        if (full !== 1'b0)    begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
        if (rdValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", rdValid); end
        if (rdData !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd_data: got %0h expected 0", rdData); end
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_flags: got ovf=%b udf=%b expected 0 0", overflow, underflow);
        end
        if (parityErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_parity: got %b expected 0", parityErr); end
    endtask

    task automatic test_fill_drain();
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i), 0, 0, 0);
            if (i == 14) begin
                checks++;
                if (full !== 1'b0) begin errors++; $display("[TB] FAIL fill_full_early: got %b expected 0", full); end
            end
        end
        checks += 2;
        if (full !== 1'b1)     begin errors++; $display("[TB] FAIL fill_full: got %b expected 1", full); end
        if (count !== 5'd16)   begin errors++; $display("[TB] FAIL fill_count: got %0d expected 16", count); end
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 0, 0);
            checks++;
            if (rdValid !== 1'b1 || rdData !== 8'(i)) begin
                errors++; $display("[TB] FAIL drain_data[%0d]: got valid=%b data=%0h expected 1 %0h", i, rdValid, rdData, i);
            end
        end
        checks += 2;
        if (empty !== 1'b1)   begin errors++; $display("[TB] FAIL drain_empty: got %b expected 1", empty); end
        if (count !== 5'd0)   begin errors++; $display("[TB] FAIL drain_count: got %0d expected 0", count); end
        step(0, 0, 0, 0, 0);
        checks++;
        if (rdValid !== 1'b0 || rdData !== 8'h0F) begin
            errors++; $display("[TB] FAIL drain_hold: got valid=%b data=%0h expected 0 0f", rdValid, rdData);
        end
    endtask

    task automatic test_overflow_underflow();
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
        step(1, 8'hAA, 0, 0, 0);
        checks += 2;
        if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
        if (count !== 5'd16)   begin errors++; $display("[TB] FAIL ovf_count: got %0d expected 16", count); end
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 0, 0);
            checks++;
            if (rdData !== 8'(8'h30 + i)) begin
                errors++; $display("[TB] FAIL ovf_readback[%0d]: got %0h expected %0h", i, rdData, 8'h30 + i);
            end
        end
        step(0, 0, 1, 0, 0);
        checks += 3;
        if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL udf_flag: got %b expected 1", underflow); end
        if (rdValid !== 1'b0)   begin errors++; $display("[TB] FAIL udf_rd_valid: got %b expected 0", rdValid); end
        if (overflow !== 1'b1)  begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_simultaneous();
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 8'($urandom), 1, 0, 0);
            checks++;
            if (count !== 5'd8 || rdValid !== 1'b1 || rdData !== mRdData) begin
                errors++;
                $display("[TB] FAIL both_half[%0d]: got count=%0d valid=%b data=%0h expected 8 1 %0h", i, count, rdValid, rdData, mRdData);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0, 0);
            checks++;
            if (rdData !== mRdData) begin errors++; $display("[TB] FAIL both_drain[%0d]: got %0h expected %0h", i, rdData, mRdData); end
        end
        step(1, 8'h77, 1, 0, 0);
        checks += 2;
        if (count !== 5'd1 || empty !== 1'b0) begin
            errors++; $display("[TB] FAIL both_empty_write: got count=%0d empty=%b expected 1 0", count, empty);
        end
        if (underflow !== 1'b1 || rdValid !== 1'b0) begin
            errors++; $display("[TB] FAIL both_empty_read: got udf=%b valid=%b expected 1 0", underflow, rdValid);
        end
        step(0, 0, 1, 0, 0);
        checks++;
        if (rdData !== 8'h77) begin errors++; $display("[TB] FAIL both_empty_data: got %0h expected 77", rdData); end
    endtask

    task automatic test_clear_reset();
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 17; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 0);
        checks++;
        if (count !== 5'd7 || overflow !== 1'b1 || underflow !== 1'b1 || rdData !== 8'h48) begin
            errors++; $display("[TB] FAIL clear_setup: got count=%0d ovf=%b udf=%b data=%0h expected 7 1 1 48", count, overflow, underflow, rdData);
        end
        step(0, 0, 1, 1, 0);
        checks += 3;
        if (count !== 5'd0 || empty !== 1'b1) begin
            errors++; $display("[TB] FAIL clear_status: got count=%0d empty=%b expected 0 1", count, empty);
        end
        if (rdValid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("[TB] FAIL clear_flags: got valid=%b ovf=%b udf=%b expected 0 0 0", rdValid, overflow, underflow);
        end
        if (rdData !== 8'h48) begin errors++; $display("[TB] FAIL clear_hold: got %0h expected 48", rdData); end
        for (int i = 0; i < 8; i++) step(1, 8'(8'h50 + i), 0, 0, 0);
        step(0, 0, 1, 0, 0);
        checks++;
        if (count !== 5'd7 || rdData !== 8'h50) begin
            errors++; $display("[TB] FAIL rst_setup: got count=%0d data=%0h expected 7 50", count, rdData);
        end
        step(0, 0, 1, 0, 1);
        checks += 2;
        if (count !== 5'd0 || empty !== 1'b1 || rdValid !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_status: got count=%0d empty=%b valid=%b expected 0 1 0", count, empty, rdValid);
        end
        if (rdData !== 8'h00) begin errors++; $display("[TB] FAIL rst_rd_data: got %0h expected 0", rdData); end
    endtask

    task automatic test_random();
        step(0, 0, 0, 0, 1);
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit w, r, c, rs;
            if ((cyc / 100) % 2 == 0) begin
                w = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 3) != 0);
            end
            c  = ($urandom_range(0, 63) == 0);
            rs = ($urandom_range(0, 127) == 0);
            step(w, 8'($urandom), r, c, rs);
            checks++;
            if (count !== 5'(q.size()) || full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
                errors++; $display("[TB] FAIL rand_status[%0d]: got count=%0d full=%b empty=%b expected count=%0d", cyc, count, full, empty, q.size());
            end
            checks++;
            if (rdValid !== mValid || rdData !== mRdData) begin
                errors++; $display("[TB] FAIL rand_read[%0d]: got valid=%b data=%0h expected %b %0h", cyc, rdValid, rdData, mValid, mRdData);
            end
            checks++;
            if (overflow !== mOvf || underflow !== mUdf || parityErr !== 1'b0) begin
                errors++; $display("[TB] FAIL rand_flags[%0d]: got ovf=%b udf=%b par=%b expected %b %b 0", cyc, overflow, underflow, parityErr, mOvf, mUdf);
            end
        end
    endtask

    task automatic test_wrap5();
        step5(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step5(1, 8'(i + 1), 0, 0);
        for (int i = 0; i < 3; i++) step5(0, 0, 1, 0);
        checks++;
        if (rdData5 !== 8'h03 || empty5 !== 1'b1) begin
            errors++; $display("[TB] FAIL wrap5_first: got data=%0h empty=%b expected 03 1", rdData5, empty5);
        end
        for (int i = 0; i < 4; i++) step5(1, 8'(8'h11 + i), 0, 0);
        checks++;
        if (count5 !== 4'd4 || full5 !== 1'b0) begin
            errors++; $display("[TB] FAIL wrap5_count: got count=%0d full=%b expected 4 0", count5, full5);
        end
        for (int i = 0; i < 4; i++) begin
            step5(0, 0, 1, 0);
            checks++;
            if (rdValid5 !== 1'b1 || rdData5 !== 8'(8'h11 + i)) begin
                errors++; $display("[TB] FAIL wrap5_data[%0d]: got valid=%b data=%0h expected 1 %0h", i, rdValid5, rdData5, 8'h11 + i);
            end
        end
        checks++;
        if (count5 !== 4'd0 || empty5 !== 1'b1) begin
            errors++; $display("[TB] FAIL wrap5_end: got count=%0d empty=%b expected 0 1", count5, empty5);
        end
        for (int i = 0; i < 5; i++) step5(1, 8'(8'h21 + i), 0, 0);
        checks++;
        if (count5 !== 4'd5 || full5 !== 1'b1) begin
            errors++; $display("[TB] FAIL wrap5_full: got count=%0d full=%b expected 5 1", count5, full5);
        end
    endtask

`ifdef FIFO_PARITY_EN
    task automatic test_parity();
        step(0, 0, 0, 0, 1);
        step(1, 8'h5A, 0, 0, 0);
        u_dut.r_mem[0][2] = ~u_dut.r_mem[0][2];
        step(0, 0, 1, 0, 0);
        checks++;
        if (parityErr !== 1'b1 || rdValid !== 1'b1) begin
            errors++; $display("[TB] FAIL parity_flip: got par=%b valid=%b expected 1 1", parityErr, rdValid);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (parityErr !== 1'b0) begin errors++; $display("[TB] FAIL parity_pulse: got %b expected 0", parityErr); end
    endtask
`endif

    initial begin
        rst = 1'b1; clear = 1'b0; wrEn = 1'b0; rdEn = 1'b0; wrData = 8'h00;
        rst5 = 1'b1; clear5 = 1'b0; wrEn5 = 1'b0; rdEn5 = 1'b0; wrData5 = 8'h00;
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_simultaneous();
        test_clear_reset();
        test_random();
        test_wrap5();
`ifdef FIFO_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
